// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the datapath's combinational load/store into a req/ack bus access and stalls the core until it completes.
// Optional bus timeout is built when DMEM_BRIDGE_TIMEOUT_EN is defined; otherwise BUSY waits for ack indefinitely and bus_err is 0.
module dmem_bridge #(
  parameter int          AW      = 16,
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic          bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        access;
  logic        stall_c;
  logic        expire;
  logic [31:0] rdata_q;

  assign access = memread | memwrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          state_nx = BUSY;
          stall_c  = 1'b1;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (bus_ack || expire) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Gate with reset so a held load/store cannot stall the core while in reset.
  assign stall   = stall_c & reset;
  assign bus_req = (state == BUSY);

  // Request attributes are captured once so they stay stable for the whole BUSY phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (state == IDLE && access) begin
      bus_we    <= memwrite;
      bus_addr  <= addr[AW-1:0];
      bus_wdata <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (state == BUSY && !bus_we) begin
      if (bus_ack) begin
        rdata_q <= bus_rdata;
      end else if (expire) begin
        rdata_q <= ERRDATA;
      end
    end
  end

  assign rdata = rdata_q;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  // Held at zero outside BUSY, which clears it on every entry to BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != BUSY) begin
      tmo_cnt <= '0;
    end else if (!bus_ack) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // An ack in the expiry cycle wins.
  assign expire = (state == BUSY) && !bus_ack && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

  assign bus_err = err_q;
`else
  logic [31:0] unused_tmo;

  assign unused_tmo = 32'(TIMEOUT);
  assign expire     = 1'b0;
  assign bus_err    = 1'b0;
`endif

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW];

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: table of load/store vectors plus reset, spurious-ack and timeout sequences.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  always #5 clk = ~clk;

  dmem_bridge #(
    .AW      (16),
    .TIMEOUT (4),
    .ERRDATA (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t sb[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] brdata;
    logic        exp_we;
    logic [15:0] exp_baddr;
    logic [31:0] exp_rdata;
    int          gap;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction's access and plays the memory with 'waits' wait states.
  task automatic do_access(input vec_t v);
    bus_t e;
    int   stalls;
    memread  = v.rd;
    memwrite = v.wr;
    addr     = v.addr;
    wdata    = v.wdata;
    sb.push_back('{we: v.exp_we, addr: v.exp_baddr, wdata: v.wdata});
    e      = '{we: 1'b0, addr: 16'h0, wdata: 32'h0};
    stalls = 0;
    @(negedge clk);
    chk("req_cycle_bus_req", 32'(bus_req), 0);
    if (stall) stalls++;
    for (int n = 0; n <= v.waits; n++) begin
      step();
      bus_ack   = (n == v.waits);
      bus_rdata = (n == v.waits) ? v.brdata : 32'h0;
      @(negedge clk);
      chk("busy_bus_req", 32'(bus_req), 1);
      if (stall) stalls++;
      if (n == 0) e = sb.pop_front();
      chk("bus_we", 32'(bus_we), 32'(e.we));
      chk("bus_addr", 32'(bus_addr), 32'(e.addr));
      chk("bus_wdata", bus_wdata, e.wdata);
    end
    step();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    @(negedge clk);
    chk("done_stall", 32'(stall), 0);
    chk("done_bus_req", 32'(bus_req), 0);
    chk("done_rdata", rdata, v.exp_rdata);
    chk("stall_cycles", 32'(stalls), 32'(v.waits + 2));
    step();
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          0, 32'h1234_5678, 1'b0, 16'h0010, 32'h1234_5678, 1};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0005, 32'hCAFE_F00D,  3, 32'h5555_5555, 1'b1, 16'h0005, 32'h1234_5678, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0001, 32'h0,          1, 32'hA5A5_0001, 1'b0, 16'h0001, 32'hA5A5_0001, 0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0BAD_F00D,  0, 32'h0,         1'b1, 16'h0002, 32'hA5A5_0001, 1};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFF_1234, 32'h1122_3344,  2, 32'h9999_9999, 1'b1, 16'h1234, 32'hA5A5_0001, 1};
    vecs[5] = '{1'b1, 1'b0, 32'h0001_FFFF, 32'h0,          0, 32'h0000_7777, 1'b0, 16'hFFFF, 32'h0000_7777, 1};

    reset     = 1'b0;
    memread   = 1'b1;
    memwrite  = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;

    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_we", 32'(bus_we), 0);
    chk("rst_bus_addr", 32'(bus_addr), 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    memread = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i]);
      for (int g = 0; g < vecs[i].gap; g++) begin
        @(negedge clk);
        chk("gap_bus_req", 32'(bus_req), 0);
        chk("gap_stall", 32'(stall), 0);
        step();
      end
    end
    chk("no_err_after_ack", 32'(bus_err), 0);

    // Spurious ack while idle must not start anything or touch rdata.
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("spur_stall", 32'(stall), 0);
    chk("spur_bus_req", 32'(bus_req), 0);
    step();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    @(negedge clk);
    chk("spur_bus_req_after", 32'(bus_req), 0);
    chk("spur_rdata", rdata, 32'h0000_7777);
    step();

    memread = 1'b1;
    addr    = 32'h0000_0007;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    @(negedge clk);
    chk("tmo_req_cycle_stall", 32'(stall), 1);
    for (int n = 0; n < 4; n++) begin
      step();
      @(negedge clk);
      chk("tmo_busy_bus_req", 32'(bus_req), 1);
    end
    step();
    @(negedge clk);
    chk("tmo_done_bus_req", 32'(bus_req), 0);
    chk("tmo_done_stall", 32'(stall), 0);
    chk("tmo_rdata", rdata, 32'hDEADBEEF);
    chk("tmo_bus_err", 32'(bus_err), 1);
    step();
    memread = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("tmo_err_sticky", 32'(bus_err), 1);
      step();
    end
    memread = 1'b1;
    addr    = 32'h0000_0009;
    step();
    step();
`else
    for (int n = 0; n < 20; n++) begin
      step();
      @(negedge clk);
      chk("hang_stall", 32'(stall), 1);
      chk("hang_bus_req", 32'(bus_req), 1);
      chk("hang_bus_err", 32'(bus_err), 0);
    end
`endif

    // Reset in the middle of a BUSY access.
    @(negedge clk);
    chk("pre_rst_bus_req", 32'(bus_req), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_bus_err", 32'(bus_err), 0);
    memread = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_bus_req", 32'(bus_req), 0);
    chk("post_rst_stall", 32'(stall), 0);
    chk("post_rst_rdata", rdata, 0);
    chk("post_rst_bus_addr", 32'(bus_addr), 0);
    step();

    do_access(vecs[0]);
    @(negedge clk);
    chk("final_bus_req", 32'(bus_req), 0);
    chk("sb_left", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle MIPS datapath. Consumes its aluout (address) and writedata outputs, and produces the readdata it consumes.
- Converts the combinational data-memory access into a req/ack handshake toward a multi-cycle memory.
- Raises a stall so the control unit freezes the PC register and register-file write until the access completes.
- Addresses are word addresses: the PC steps by 1, so there is no byte offset.

Parameters:
- AW, 16, width of bus_addr; low AW bits of addr are forwarded.
- TIMEOUT, 255, max cycles waiting for bus_ack (used only with the optional feature).
- ERRDATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- memread  in  1  datapath requests a load this instruction.
- memwrite  in  1  datapath requests a store this instruction.
- addr  in  32  word address (datapath aluout).
- wdata  in  32  store data (datapath writedata).
- rdata  out  32  load data to datapath readdata.
- stall  out  1  1 = hold PC and suppress regwrite this cycle.
- bus_req  out  1  request to memory; held until bus_ack.
- bus_we  out  1  1 = write, 0 = read; stable while bus_req=1.
- bus_addr  out  AW  latched address; stable while bus_req=1.
- bus_wdata  out  32  latched store data; stable while bus_req=1.
- bus_ack  in  1  memory completes the access this cycle (single-cycle pulse).
- bus_rdata  in  32  read data, valid when bus_ack=1.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, BUSY, DONE. Registered state; async reset forces IDLE.
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata register=0, bus_err=0. stall=0 while reset is asserted.
- IDLE:
  - If memread|memwrite: latch addr[AW-1:0], wdata and we=memwrite; go to BUSY.
  - stall=1 combinationally in this same cycle, so the PC does not advance.
  - If both memread and memwrite are 1, the write wins (bus_we=1).
  - Otherwise stay in IDLE with stall=0.
- BUSY:
  - bus_req=1 and stall=1.
  - On bus_ack=1: capture bus_rdata into the rdata register (reads only; a write leaves rdata unchanged), drop bus_req, go to DONE.
  - bus_ack seen in IDLE or DONE is ignored.
- DONE:
  - Lasts exactly 1 cycle with stall=0 and rdata = captured value; the datapath commits regwrite and the PC at the following edge.
  - Next state is always IDLE. The next instruction's access, if any, is detected there, so an access is never reissued.
- rdata output is the registered value in every state.
- Minimum access cost: request cycle (IDLE) + 1 BUSY cycle if ack arrives on the first BUSY cycle + DONE. Zero-wait memory therefore costs 2 stall cycles.
- Address bits 31:AW are ignored.
- Reset mid-BUSY: bus_req drops asynchronously, state goes to IDLE, and the access is abandoned. The memory must tolerate a withdrawn request.
- Outputs bus_we, bus_addr and bus_wdata change only on the IDLE→BUSY transition.

Optional Feature:
- Macro DMEM_BRIDGE_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter (wide enough for TIMEOUT) clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: drop bus_req, load rdata=ERRDATA on reads, set bus_err=1 (sticky until reset), and go to DONE.
  - An ack arriving in the same cycle as expiry wins, and bus_err is not set.
- When undefined: BUSY waits indefinitely, no counter exists, and bus_err is tied to 0.

Test Plan:
- Reset: reset=0 mid-BUSY with bus_req=1 → bus_req=0 immediately, stall=0. After release, state is IDLE and rdata=0.
- Load, zero wait: memread=1, addr=32'h00000010, bus_ack in the first BUSY cycle with bus_rdata=32'h12345678 → stall=1 for 2 cycles, then rdata=32'h12345678 with stall=0 for 1 cycle, and bus_addr=16'h0010.
- Store, 3 wait states: memwrite=1, addr=5, wdata=32'hCAFEF00D → bus_we=1, bus_wdata=32'hCAFEF00D held stable for 4 BUSY cycles until ack. stall=1 for 5 cycles, and rdata stays unchanged.
- Back-to-back: load to addr 1 then store to addr 2 on consecutive instructions → exactly two bus transactions, each req preceded by a DONE/IDLE gap. No duplicate request.
- Simultaneous memread=memwrite=1, plus a spurious bus_ack while IDLE → single write transaction, and the spurious ack causes no state change.
- Timeout with DMEM_BRIDGE_TIMEOUT_EN, TIMEOUT=4, no ack on a load → bus_req drops after 4 BUSY cycles, rdata=32'hDEADBEEF, and bus_err=1 persists until reset. Without the macro, stall stays 1 indefinitely and bus_err=0.
